inv_quant_qt_qscale: RTL and testbench
======================================

// Module: inv_quant_qt_qscale
// PURPOSE
//  Inverse quantizer for the decode/reconstruction path: OUT = (IN * QSCALE * QMAT) >>> 2.
//  Accepts one 8x8 quantized coefficient block per handshake and processes one row per cycle
//  on 8 multiplier lanes. Presents the dequantized block to the downstream IDCT with valid/ready.
//  Luma or chroma matrix is chosen per block.
// PARAMETERS
//  DATA_W   32  signed width of coefficients, QSCALE, QMAT entries and outputs
//  SHIFT    2   arithmetic right shift applied to the product (undoes the encoder's <<2)
//  SAT_W    16  signed saturation width, used only when INV_QUANT_SAT_EN is defined
// PORTS
//  CLOCK         in   1             clock, all state on rising edge
//  RESET         in   1             asynchronous, active-low reset
//  input_valid   in   1             INPUT_DATA/QSCALE/is_y valid
//  input_ready   out  1             block can be accepted
//  INPUT_DATA    in   DATA_W[8][8]  quantized coefficients, signed
//  QSCALE        in   DATA_W        quantizer scale, signed, sampled at accept
//  is_y          in   1             1: use Y_QMAT, 0: use C_QMAT; sampled at accept
//  Y_QMAT        in   DATA_W[8][8]  luma matrix, stable while block is busy
//  C_QMAT        in   DATA_W[8][8]  chroma matrix, stable while block is busy
//  output_valid  out  1             OUTPUT_DATA holds a complete block
//  output_ready  in   1             downstream accepts block
//  OUTPUT_DATA   out  DATA_W[8][8]  dequantized coefficients, signed
// BEHAVIOUR
//  - Reset (RESET=0, async): state IDLE, row counter 0, output_valid=0, OUTPUT_DATA all 0,
//    input_ready=1 after reset releases. The captured block is discarded.
//  - FSM: IDLE -> CALC on input_valid&&input_ready (accept): INPUT_DATA, QSCALE, is_y latched.
//    CALC: each cycle computes row r (8 lanes), writes OUTPUT_DATA[r][0..7], r++.
//    CALC -> DONE on the edge that writes row 7; counter wraps to 0.
//    DONE -> IDLE on output_valid&&output_ready.
//  - input_ready = (state==IDLE). output_valid = (state==DONE).
//  - Latency: accept at edge t0; rows written at t0+1..t0+8; output_valid=1 after t0+8.
//  - Throughput: with output_ready held high, one block per 10 cycles.
//  - Backpressure: in DONE with output_ready=0, OUTPUT_DATA and output_valid hold; no accept.
//  - input_valid outside IDLE is ignored; the source holds data until accepted.
//  - Arithmetic: lane product = IN*QSCALE*QMAT in full 3*DATA_W signed precision, then >>> SHIFT.
//    Rounding is floor, so -3 -> -1. Without saturation the result is truncated to DATA_W.
//  - QSCALE=0 or QMAT entry 0 -> output 0, with no special casing.
//  - OUTPUT_DATA rows not yet rewritten in CALC keep stale values; they are only meaningful
//    when output_valid=1.
// CONFIGURATION
//  INV_QUANT_SAT_EN defined:
//    - Each shifted result is clamped to [-(2**(SAT_W-1)), 2**(SAT_W-1)-1].
//    - The clamped value is sign-extended to DATA_W.
//  INV_QUANT_SAT_EN undefined:
//    - No clamp; the shifted result is truncated to DATA_W (two's-complement wrap).
// TESTING
//  1 IN all 5, QSCALE=4, Y_QMAT all 4, is_y=1 -> all OUTPUT_DATA=20; output_valid 8 cycles after accept.
//  2 IN all -3, QSCALE=1, C_QMAT all 1, is_y=0 -> all -1 (floor); Y_QMAT=9 must not affect result.
//  3 IN[0][0]=30000, QSCALE=8, QMAT[0][0]=8 -> 480000 without macro; 32767 with INV_QUANT_SAT_EN;
//    -30000 gives -32768 with the macro.
//  4 output_ready=0 for 5 cycles in DONE -> OUTPUT_DATA stable, input_ready=0, second input_valid
//    ignored; after ready high for 1 cycle -> IDLE, next block accepted the following cycle.
//  5 Assert RESET=0 mid-CALC (row 3) -> output_valid=0 and OUTPUT_DATA=0 immediately (async);
//    after release input_ready=1 and no stale output_valid.
//  6 Back-to-back: 3 blocks, output_ready=1 -> 3 output_valid pulses 10 cycles apart, values correct.

Source files
------------

// File: rtl/inv_quant_qt_qscale.sv
// Row-serial 8x8 inverse quantizer: OUT = (IN * QSCALE * QMAT) >>> SHIFT, one row per cycle.
// Define INV_QUANT_SAT_EN to clamp each result to SAT_W signed bits.

module inv_quant_qt_qscale #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SHIFT  = 2,
    parameter int unsigned SAT_W  = 16
) (
    input  logic                        CLOCK,
    input  logic                        RESET,
    input  logic                        input_valid,
    output logic                        input_ready,
    input  logic [7:0][7:0][DATA_W-1:0] INPUT_DATA,
    input  logic [DATA_W-1:0]           QSCALE,
    input  logic                        is_y,
    input  logic [7:0][7:0][DATA_W-1:0] Y_QMAT,
    input  logic [7:0][7:0][DATA_W-1:0] C_QMAT,
    output logic                        output_valid,
    input  logic                        output_ready,
    output logic [7:0][7:0][DATA_W-1:0] OUTPUT_DATA
);

    localparam int unsigned PROD_W = 3 * DATA_W;

    if (SAT_W < 2 || SAT_W > DATA_W) begin : g_sat_w_check
        $error("SAT_W must lie in [2, DATA_W]");
    end

`ifdef INV_QUANT_SAT_EN
    localparam logic signed [PROD_W-1:0] SAT_MAX =
        {{(PROD_W - SAT_W + 1){1'b0}}, {(SAT_W - 1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN =
        {{(PROD_W - SAT_W + 1){1'b1}}, {(SAT_W - 1){1'b0}}};
`endif

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t                        state_q;
    logic [2:0]                    row_q;
    logic [7:0][7:0][DATA_W-1:0]   in_q;
    logic [DATA_W-1:0]             qscale_q;
    logic                          is_y_q;

    logic signed [PROD_W-1:0]      lane_qs;
    logic signed [PROD_W-1:0]      lane_in    [8];
    logic signed [PROD_W-1:0]      lane_qm    [8];
    logic signed [PROD_W-1:0]      lane_shift [8];
    logic [7:0][DATA_W-1:0]        row_res;

    assign input_ready  = (state_q == StIdle);
    assign output_valid = (state_q == StDone);

    // Operands are sign-extended to the full product width so the triple product never overflows.
    always_comb begin
        lane_qs = {{(PROD_W - DATA_W){qscale_q[DATA_W-1]}}, qscale_q};
        row_res = '0;
        for (int c = 0; c < 8; c++) begin
            lane_in[c] = {{(PROD_W - DATA_W){in_q[row_q][c][DATA_W-1]}}, in_q[row_q][c]};
            lane_qm[c] = is_y_q
                ? {{(PROD_W - DATA_W){Y_QMAT[row_q][c][DATA_W-1]}}, Y_QMAT[row_q][c]}
                : {{(PROD_W - DATA_W){C_QMAT[row_q][c][DATA_W-1]}}, C_QMAT[row_q][c]};
            lane_shift[c] = (lane_in[c] * lane_qs * lane_qm[c]) >>> SHIFT;
`ifdef INV_QUANT_SAT_EN
            if (lane_shift[c] > SAT_MAX) begin
                row_res[c] = DATA_W'(SAT_MAX);
            end else if (lane_shift[c] < SAT_MIN) begin
                row_res[c] = DATA_W'(SAT_MIN);
            end else begin
                row_res[c] = DATA_W'(lane_shift[c]);
            end
`else
            row_res[c] = DATA_W'(lane_shift[c]);
`endif
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= StIdle;
            row_q       <= '0;
            in_q        <= '0;
            qscale_q    <= '0;
            is_y_q      <= 1'b0;
            OUTPUT_DATA <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (input_valid) begin
                        in_q     <= INPUT_DATA;
                        qscale_q <= QSCALE;
                        is_y_q   <= is_y;
                        row_q    <= '0;
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
                    OUTPUT_DATA[row_q] <= row_res;
                    row_q              <= row_q + 3'd1;
                    if (row_q == 3'd7) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (output_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_quant_qt_qscale.sv
// Self-checking bench for inv_quant_qt_qscale: scoreboard of expected blocks, one task per scenario.
// Expected values follow INV_QUANT_SAT_EN when it is defined for the build.

module tb_inv_quant_qt_qscale;

    typedef logic [7:0][7:0][31:0] blk_t;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        input_valid = 1'b0;
    logic        input_ready;
    blk_t        INPUT_DATA = '0;
    logic [31:0] QSCALE = '0;
    logic        is_y = 1'b0;
    blk_t        Y_QMAT = '0;
    blk_t        C_QMAT = '0;
    logic        output_valid;
    logic        output_ready = 1'b0;
    blk_t        OUTPUT_DATA;

    blk_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    inv_quant_qt_qscale #(
        .DATA_W(32),
        .SHIFT (2),
        .SAT_W (16)
    ) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .input_valid (input_valid),
        .input_ready (input_ready),
        .INPUT_DATA  (INPUT_DATA),
        .QSCALE      (QSCALE),
        .is_y        (is_y),
        .Y_QMAT      (Y_QMAT),
        .C_QMAT      (C_QMAT),
        .output_valid(output_valid),
        .output_ready(output_ready),
        .OUTPUT_DATA (OUTPUT_DATA)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [31:0] model_elem(input logic signed [31:0] a,
                                               input logic signed [31:0] q,
                                               input logic signed [31:0] m);
        logic signed [95:0] p;
        p = a;
        p = p * q;
        p = p * m;
        p = p >>> 2;
`ifdef INV_QUANT_SAT_EN
        if (p > 96'sd32767) return 32'sd32767;
        if (p < -96'sd32768) return -32'sd32768;
`endif
        return 32'(p);
    endfunction

    function automatic blk_t model_blk(input blk_t d, input logic [31:0] q, input blk_t m);
        blk_t r;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                r[i][j] = model_elem(d[i][j], q, m[i][j]);
        return r;
    endfunction

    function automatic blk_t fill(input logic [31:0] v);
        blk_t r;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                r[i][j] = v;
        return r;
    endfunction

    function automatic blk_t rand_blk(input int span, input int base);
        blk_t r;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                r[i][j] = 32'(int'($urandom_range(0, 2 * span)) - span + base);
        return r;
    endfunction

    function automatic string diff_str(input blk_t got, input blk_t want);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (got[i][j] !== want[i][j])
                    return $sformatf("[%0d][%0d] got %0d want %0d", i, j,
                                     $signed(got[i][j]), $signed(want[i][j]));
        return "no element differs";
    endfunction

    // Drives one block and waits (bounded) for its accept edge; pushes the expected result.
    task automatic send(input blk_t d, input logic [31:0] q, input logic y, output bit ok);
        INPUT_DATA  = d;
        QSCALE      = q;
        is_y        = y;
        input_valid = 1'b1;
        ok          = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (input_ready) begin
                @(posedge CLOCK); #1;
                ok = 1'b1;
                break;
            end
            @(posedge CLOCK); #1;
        end
        input_valid = 1'b0;
        if (ok) exp_q.push_back(model_blk(d, q, y ? Y_QMAT : C_QMAT));
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!output_valid && cyc < 40) begin
            @(posedge CLOCK); #1;
            cyc++;
        end
    endtask

    task automatic drain();
        output_ready = 1'b1;
        @(posedge CLOCK); #1;
        output_ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (output_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", output_valid);
        end
        n_checks++;
        if (OUTPUT_DATA !== '0) begin
            n_fail++; $display("FAIL reset_data: %s", diff_str(OUTPUT_DATA, '0));
        end
        @(posedge CLOCK); #1;
        RESET = 1'b1;
        @(posedge CLOCK); #1;
        n_checks++;
        if (input_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", input_ready);
        end
    endtask

    // Sends one block, checks latency and result against the scoreboard, then drains it.
    task automatic run_block(input string name, input blk_t d, input logic [31:0] q, input logic y,
                             input int ci, input int cj, input logic [31:0] cval, input bit cchk);
        bit ok;
        int cyc;
        send(d, q, y, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL %s_accept: got no accept want accept", name);
        end
        wait_valid(cyc);
        n_checks++;
        if (cyc != 8) begin
            n_fail++; $display("FAIL %s_latency: got %0d cycles want 8", name, cyc);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL %s_data: got empty scoreboard want 1 entry", name);
        end else if (OUTPUT_DATA !== exp_q[0]) begin
            n_fail++; $display("FAIL %s_data: %s", name, diff_str(OUTPUT_DATA, exp_q[0]));
        end
        if (cchk) begin
            n_checks++;
            if (OUTPUT_DATA[ci][cj] !== cval) begin
                n_fail++; $display("FAIL %s_const: got %0d want %0d", name,
                                   $signed(OUTPUT_DATA[ci][cj]), $signed(cval));
            end
        end
        drain();
    endtask

    task automatic test_arith();
        blk_t d;
        logic [31:0] sat_pos;
        logic [31:0] sat_neg;
        Y_QMAT = fill(4);
        C_QMAT = fill(7);
        run_block("all5", fill(5), 32'd4, 1'b1, 3, 5, 32'd20, 1'b1);
        Y_QMAT = fill(9);
        C_QMAT = fill(1);
        run_block("floor", fill(-32'sd3), 32'd1, 1'b0, 7, 7, -32'sd1, 1'b1);
`ifdef INV_QUANT_SAT_EN
        sat_pos = 32'sd32767;
        sat_neg = -32'sd32768;
`else
        sat_pos = 32'sd480000;
        sat_neg = -32'sd480000;
`endif
        Y_QMAT = '0;
        Y_QMAT[0][0] = 32'd8;
        d = '0;
        d[0][0] = 32'sd30000;
        run_block("big_pos", d, 32'd8, 1'b1, 0, 0, sat_pos, 1'b1);
        d[0][0] = -32'sd30000;
        run_block("big_neg", d, 32'd8, 1'b1, 0, 0, sat_neg, 1'b1);
        Y_QMAT = rand_blk(120, 128);
        C_QMAT = rand_blk(120, 128);
        run_block("qscale0", rand_blk(1000, 0), 32'd0, 1'b1, 4, 2, 32'd0, 1'b1);
        run_block("rand_y", rand_blk(1000, 0), 32'd13, 1'b1, 0, 0, 32'd0, 1'b0);
        run_block("rand_c", rand_blk(1000, 0), -32'sd7, 1'b0, 0, 0, 32'd0, 1'b0);
    endtask

    task automatic test_backpressure();
        bit   ok;
        int   cyc;
        blk_t held;
        blk_t blk_b;
        send(rand_blk(500, 0), 32'd3, 1'b1, ok);
        wait_valid(cyc);
        n_checks++;
        if (!ok || cyc != 8 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL bp_setup: got accept=%0d latency=%0d want 1 and 8", ok, cyc);
            held = '0;
        end else begin
            held = exp_q[0];
        end
        blk_b       = rand_blk(500, 0);
        INPUT_DATA  = blk_b;
        QSCALE      = 32'd5;
        is_y        = 1'b0;
        input_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge CLOCK); #1;
            n_checks++;
            if (OUTPUT_DATA !== held || output_valid !== 1'b1 || input_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got valid=%b ready=%b %s want valid=1 ready=0", k,
                         output_valid, input_ready, diff_str(OUTPUT_DATA, held));
            end
        end
        drain();
        n_checks++;
        if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got valid=%b ready=%b want 0 1",
                               output_valid, input_ready);
        end
        exp_q.push_back(model_blk(blk_b, 32'd5, C_QMAT));
        @(posedge CLOCK); #1;
        input_valid = 1'b0;
        n_checks++;
        if (input_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_next_accept: got ready=%b want 0", input_ready);
        end
        wait_valid(cyc);
        n_checks++;
        if (cyc != 8 || exp_q.size() == 0 || OUTPUT_DATA !== exp_q[0]) begin
            n_fail++; $display("FAIL bp_next_data: got latency %0d want 8, %s", cyc,
                               exp_q.size() == 0 ? "empty" : diff_str(OUTPUT_DATA, exp_q[0]));
        end
        drain();
    endtask

    task automatic test_async_reset();
        bit ok;
        int seen;
        send(rand_blk(800, 0), 32'd9, 1'b1, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL ar_accept: got no accept want accept");
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge CLOCK); #1;
        end
        #2;
        RESET = 1'b0;
        #1;
        n_checks++;
        if (output_valid !== 1'b0 || OUTPUT_DATA !== '0) begin
            n_fail++; $display("FAIL ar_immediate: got valid=%b %s want valid=0 data 0",
                               output_valid, diff_str(OUTPUT_DATA, '0));
        end
        exp_q.delete();
        #2;
        RESET = 1'b1;
        @(posedge CLOCK); #1;
        n_checks++;
        if (input_ready !== 1'b1 || output_valid !== 1'b0) begin
            n_fail++; $display("FAIL ar_release: got ready=%b valid=%b want 1 0",
                               input_ready, output_valid);
        end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge CLOCK); #1;
            if (output_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL ar_stale_valid: got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        blk_t        blks [3];
        logic [31:0] qs   [3];
        logic        ys   [3];
        int          pulses[$];
        int          idx;
        for (int b = 0; b < 3; b++) begin
            blks[b] = rand_blk(1000, 0);
            qs[b]   = 32'($urandom_range(1, 31));
            ys[b]   = (b != 1);
        end
        idx          = 0;
        output_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (output_valid) begin
                pulses.push_back(cyc);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_data: got output with empty scoreboard");
                end else begin
                    if (OUTPUT_DATA !== exp_q[0]) begin
                        n_fail++; $display("FAIL b2b_data: %s", diff_str(OUTPUT_DATA, exp_q[0]));
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (idx < 3) begin
                INPUT_DATA  = blks[idx];
                QSCALE      = qs[idx];
                is_y        = ys[idx];
                input_valid = 1'b1;
                if (input_ready) begin
                    exp_q.push_back(model_blk(blks[idx], qs[idx], ys[idx] ? Y_QMAT : C_QMAT));
                    idx++;
                end
            end else begin
                input_valid = 1'b0;
            end
            @(posedge CLOCK); #1;
        end
        output_ready = 1'b0;
        input_valid  = 1'b0;
        n_checks++;
        if (pulses.size() != 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d pulses want 3", pulses.size());
        end else begin
            n_checks++;
            if (pulses[1] - pulses[0] != 10 || pulses[2] - pulses[1] != 10) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d,%0d want 10,10",
                                   pulses[1] - pulses[0], pulses[2] - pulses[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
